// File: rtl/mem_stage_if.sv
// mem_stage_if -- data-memory bus between the memory stage and the data memory.
//
// Signals:
//   req    stage -> memory  access request, held until the ack cycle
//   we     stage -> memory  write strobe (store)
//   addr   stage -> memory  word-aligned byte address
//   be     stage -> memory  byte-lane enables, little-endian
//   wdata  stage -> memory  lane-replicated store data
//   ack    memory -> stage  access complete this cycle
//   rdata  memory -> stage  read data, valid with ack
//
// Modports: master (memory stage), slave (data memory).
interface mem_stage_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 32
);
  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata;
  logic                 ack;
  logic [WORD_SIZE-1:0] rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage -- pipeline memory-access stage.
//
// Accepts one operation from execute when idle. ALU-only operations complete
// in one cycle; loads/stores issue a single data-memory access and complete on
// the memory's ack. Results are registered and presented to writeback for one
// cycle; downstream never stalls.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        upstream handshake (in_ready high when idle)
//   alu_result, store_data     ALU result / byte address, right-aligned store data
//   mem_read, mem_write        load / store request (both high = store)
//   mem_size, mem_signed       00 byte, 01 half, 1x word; load sign-extension
//   rd_addr_in, reg_write_in   destination register and its write enable
//   dmem                       data-memory bus (mem_stage_if.master)
//   out_valid, alu_data, mem_data, rd_data_sel, rd_addr, reg_write, misalign
//                              registered results for writeback
//
// Configuration macro: MEM_ALIGN_CHECK_EN -- when defined, misaligned half/word
// accesses are not issued and complete at once with misalign set; when
// undefined, misalign is always 0 and the low address bits are ignored.
module mem_stage #(
  parameter int WORD_SIZE     = 32,
  parameter int ADDR_SIZE     = 32,
  parameter int REG_ADDR_SIZE = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WORD_SIZE-1:0]     alu_result,
  input  logic [WORD_SIZE-1:0]     store_data,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [1:0]               mem_size,
  input  logic                     mem_signed,
  input  logic [REG_ADDR_SIZE-1:0] rd_addr_in,
  input  logic                     reg_write_in,
  mem_stage_if.master              dmem,
  output logic                     out_valid,
  output logic [WORD_SIZE-1:0]     alu_data,
  output logic [WORD_SIZE-1:0]     mem_data,
  output logic                     rd_data_sel,
  output logic [REG_ADDR_SIZE-1:0] rd_addr,
  output logic                     reg_write,
  output logic                     misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t state, next_state;

  logic [WORD_SIZE-1:0]     op_alu_q;
  logic [REG_ADDR_SIZE-1:0] op_rd_q;
  logic                     op_rw_q;
  logic                     op_load_q;
  logic                     op_we_q;
  logic [1:0]               op_size_q;
  logic                     op_signed_q;
  logic [1:0]               op_lo_q;
  logic [ADDR_SIZE-1:0]     op_addr_q;
  logic [3:0]               op_be_q;
  logic [WORD_SIZE-1:0]     op_wdata_q;

  logic                 accept;
  logic                 mem_op;
  logic                 misaligned_in;
  logic                 start_access;
  logic                 direct_done;
  logic                 mem_done;
  logic [3:0]           be_in;
  logic [WORD_SIZE-1:0] wdata_in;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] load_data;

  `ifdef MEM_ALIGN_CHECK_EN
  assign misaligned_in = mem_op &&
                         (((mem_size == 2'b01) && alu_result[0]) ||
                          (mem_size[1] && (alu_result[1:0] != 2'b00)));
  `else
  assign misaligned_in = 1'b0;
  `endif

  assign accept       = in_valid && (state == S_IDLE);
  assign mem_op       = mem_read || mem_write;
  assign start_access = accept && mem_op && !misaligned_in;
  assign direct_done  = accept && (!mem_op || misaligned_in);
  assign mem_done     = (state == S_WAIT) && dmem.ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Bus fields come straight from the latched request so they stay stable
  // for the whole access; they are forced to 0 while idle.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    dmem.req   = 1'b0;
    dmem.we    = 1'b0;
    dmem.addr  = '0;
    dmem.be    = '0;
    dmem.wdata = '0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (start_access) next_state = S_WAIT;
      end
      S_WAIT: begin
        dmem.req   = 1'b1;
        dmem.we    = op_we_q;
        dmem.addr  = op_addr_q;
        dmem.be    = op_be_q;
        dmem.wdata = op_wdata_q;
        if (dmem.ack) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Little-endian lane selection; half accesses only look at address bit 1.
  always_comb begin
    be_in    = 4'b1111;
    wdata_in = store_data;
    case (mem_size)
      2'b00: begin
        be_in    = 4'b0001 << alu_result[1:0];
        wdata_in = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_in    = alu_result[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = dmem.rdata;
    load_data = dmem.rdata;
    case (op_size_q)
      2'b00: begin
        shifted   = dmem.rdata >> {op_lo_q, 3'b000};
        load_data = op_signed_q ? {{24{shifted[7]}}, shifted[7:0]}
                                : {24'h0, shifted[7:0]};
      end
      2'b01: begin
        shifted   = dmem.rdata >> {op_lo_q[1], 4'b0000};
        load_data = op_signed_q ? {{16{shifted[15]}}, shifted[15:0]}
                                : {16'h0, shifted[15:0]};
      end
      default: load_data = shifted;
    endcase
  end

  // A simultaneous read+write is a store: it never selects load data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_alu_q    <= '0;
      op_rd_q     <= '0;
      op_rw_q     <= 1'b0;
      op_load_q   <= 1'b0;
      op_we_q     <= 1'b0;
      op_size_q   <= 2'b00;
      op_signed_q <= 1'b0;
      op_lo_q     <= 2'b00;
      op_addr_q   <= '0;
      op_be_q     <= '0;
      op_wdata_q  <= '0;
    end else if (start_access) begin
      op_alu_q    <= alu_result;
      op_rd_q     <= rd_addr_in;
      op_rw_q     <= reg_write_in;
      op_load_q   <= mem_read && !mem_write;
      op_we_q     <= mem_write;
      op_size_q   <= mem_size;
      op_signed_q <= mem_signed;
      op_lo_q     <= alu_result[1:0];
      op_addr_q   <= {alu_result[ADDR_SIZE-1:2], 2'b00};
      op_be_q     <= be_in;
      op_wdata_q  <= wdata_in;
    end
  end

  // out_valid, reg_write and misalign are single-cycle pulses; the data
  // fields simply hold their last value between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      alu_data    <= '0;
      mem_data    <= '0;
      rd_data_sel <= 1'b0;
      rd_addr     <= '0;
      reg_write   <= 1'b0;
      misalign    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      reg_write <= 1'b0;
      misalign  <= 1'b0;
      if (direct_done) begin
        out_valid   <= 1'b1;
        alu_data    <= alu_result;
        mem_data    <= '0;
        rd_data_sel <= 1'b0;
        rd_addr     <= rd_addr_in;
        reg_write   <= reg_write_in && !misaligned_in;
        misalign    <= misaligned_in;
      end else if (mem_done) begin
        out_valid   <= 1'b1;
        alu_data    <= op_alu_q;
        mem_data    <= op_load_q ? load_data : '0;
        rd_data_sel <= op_load_q;
        rd_addr     <= op_rd_q;
        reg_write   <= op_rw_q;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter WORD_SIZE, default 32, data path width in bits; only 32 is supported.
REQ-002 Parameter ADDR_SIZE, default 32, data memory byte-address width.
REQ-003 Parameter REG_ADDR_SIZE, default 5, register file address width.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  upstream (execute) presents an operation.
REQ-007 in_ready  output  1  stage can accept an operation this cycle.
REQ-008 alu_result  input  WORD_SIZE  ALU result / effective byte address.
REQ-009 store_data  input  WORD_SIZE  store operand, right-aligned.
REQ-010 mem_read, mem_write  input  1 each  load / store request.
REQ-011 mem_size  input  2  00 byte, 01 half, 10 word; 11 treated as word.
REQ-012 mem_signed  input  1  sign-extend loads when high, zero-extend when low.
REQ-013 rd_addr_in, reg_write_in  input  REG_ADDR_SIZE, 1  destination and write enable.
REQ-014 dmem_req, dmem_we  output  1 each  memory request and write strobe.
REQ-015 dmem_addr  output  ADDR_SIZE  word-aligned address (bits [1:0] = 0).
REQ-016 dmem_be, dmem_wdata  output  4, WORD_SIZE  byte enables and write data.
REQ-017 dmem_ack, dmem_rdata  input  1, WORD_SIZE  completion and read data, valid with ack.
REQ-018 out_valid, alu_data, mem_data, rd_data_sel, rd_addr, reg_write, misalign  output  1, W, W, 1, REG_ADDR_SIZE, 1, 1  registered results for the writeback stage.

Function
REQ-019 Two states, IDLE and WAIT; in_ready SHALL equal (state == IDLE).
REQ-020 IDLE, in_valid, no memory op: outputs load at the next edge, out_valid high for exactly one cycle (latency 1).
REQ-021 IDLE, in_valid, mem_read or mem_write: request fields latch, state -> WAIT; dmem_req high from the next cycle.
REQ-022 In WAIT, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata SHALL be held stable until the dmem_ack cycle inclusive.
REQ-023 On dmem_ack in WAIT: outputs load at that edge, state -> IDLE, out_valid high one cycle; ack in the first WAIT cycle gives latency 2.
REQ-024 dmem_ack outside WAIT SHALL be ignored.
REQ-025 Both mem_read and mem_write high: treated as store only; rd_data_sel = 0.
REQ-026 Byte lanes little-endian by address[1:0]: byte be = 1 << a[1:0], data replicated x4; half be = a[1] ? 1100 : 0011, data replicated x2; word be = 1111.
REQ-027 Load: dmem_rdata shifted right 8*a[1:0] (half: 16*a[1]), truncated to size, then sign/zero extended per mem_signed.
REQ-028 alu_data = latched alu_result; rd_data_sel = load; mem_data = extended load data for loads, 0 otherwise.
REQ-029 rd_addr and reg_write pass through with the operation; when out_valid is low, reg_write SHALL be 0.
REQ-030 Downstream SHALL NOT backpressure; results are presented once.

Reset
REQ-031 rst_n low asynchronously: state IDLE, every output 0 except in_ready = 1.
REQ-032 Reset during WAIT aborts the access; dmem_req drops immediately; a later ack is ignored.

Configuration
REQ-033 Macro MEM_ALIGN_CHECK_EN defined: half with a[0] = 1 or word with a[1:0] != 0 issues no dmem transaction; result in 1 cycle with misalign = 1, reg_write = 0.
REQ-034 Macro undefined: misalign tied 0; misaligned half ignores a[0], word ignores a[1:0].

Verification
REQ-035 ALU op: alu_result 0x1234, reg_write_in 1, rd 7 -> next cycle out_valid 1, alu_data 0x1234, rd_data_sel 0, reg_write 1, rd_addr 7.
REQ-036 Signed byte load, addr 0x103, rdata 0x80FF_0000, ack after 3 WAIT cycles -> dmem_addr 0x100, mem_data 0xFFFF_FF80, in_ready low throughout WAIT.
REQ-037 Half store 0xBEEF at addr 0x22 -> dmem_we 1, be 1100, wdata 0xBEEF_BEEF, dmem_addr 0x20; mem_data 0, rd_data_sel 0.
REQ-038 Unsigned half load at 0x02, rdata 0x8001_0000, ack in first WAIT cycle -> out_valid 2 cycles after accept, mem_data 0x0000_8001.
REQ-039 rst_n low in WAIT then ack -> dmem_req 0 at once, no out_valid, in_ready 1 after release.
REQ-040 MEM_ALIGN_CHECK_EN, word load at 0x06 -> no dmem_req, misalign 1, reg_write 0 next cycle; undefined -> access at 0x04, be 1111.
